mem_arbiter: RTL and testbench

//  Two-port arbiter sharing one synchronous single-port RAM (main memory) between the i8080 CPU
//  and a DMA/loader requester (serial loader, front-panel examine/deposit).

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between the i8080 CPU
// and the DMA/loader port. Every access walks IDLE -> ISSUE -> CAPT -> ACK so
// the one-cycle registered RAM read latency is absorbed inside the arbiter.
// The CPU has fixed priority. A saturating wait counter forces a DMA grant
// once the DMA port has lost DMA_MAX_WAIT arbitrations in a row.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_rd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_t;

  localparam logic [3:0] MAX_WAIT = 4'(DMA_MAX_WAIT);
  localparam logic [3:0] WAIT_SAT = 4'hF;

  state_t                  state;
  state_t                  state_next;
  grant_t                  grant_r;
  grant_t                  grant_next;
  logic [3:0]              wait_cnt;
  logic [3:0]              wait_cnt_next;
  logic                    load;
  logic                    we_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Control registers: FSM state, current grant owner and DMA starvation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant_r  <= GNT_CPU;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      grant_r  <= grant_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state, arbitration and RAM/ack strobes; strobes decode the current state.
  always_comb begin
    state_next    = state;
    grant_next    = grant_r;
    wait_cnt_next = wait_cnt;
    load          = 1'b0;
    mem_rd        = 1'b0;
    mem_we        = 1'b0;
    cpu_ack       = 1'b0;
    dma_ack       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          load       = 1'b1;
          state_next = ST_ISSUE;
          if (dma_req && (!cpu_req || (wait_cnt >= MAX_WAIT))) begin
            grant_next    = GNT_DMA;
            wait_cnt_next = '0;
          end else begin
            grant_next = GNT_CPU;
            if (dma_req && (wait_cnt != WAIT_SAT)) begin
              wait_cnt_next = wait_cnt + 4'd1;
            end
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_CAPT;
        mem_rd     = ~we_r;
        mem_we     = we_r & ~reset;
      end
      ST_CAPT: begin
        state_next = ST_ACK;
      end
      ST_ACK: begin
        state_next = ST_IDLE;
        cpu_ack    = (grant_r == GNT_CPU);
        dma_ack    = (grant_r == GNT_DMA);
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Steer the winning port's request fields toward the latch registers.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_next == GNT_DMA) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // Latch the granted request and capture read data one cycle after mem_rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_data_in <= '0;
      we_r        <= 1'b0;
      rdata_r     <= '0;
    end else begin
      if (load) begin
        mem_addr    <= sel_addr;
        mem_data_in <= sel_wdata;
        we_r        <= sel_we;
      end
      if ((state == ST_CAPT) && !we_r) begin
        rdata_r <= mem_data_out;
      end
    end
  end

  assign cpu_rdata = rdata_r;
  assign dma_rdata = rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single accesses, hand-written multi-cycle
// corner cases and a randomized two-requester run against a cycle-timeline
// reference model with a shadow copy of main memory.
module tb_mem_arbiter;

  localparam int AW      = 13;
  localparam int DW      = 8;
  localparam int MAXWAIT = 4;
  localparam int NRAND   = 3000;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_rd, mem_we;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  int n_checks;
  int n_fail;

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DMA_MAX_WAIT(MAXWAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_rdata   (dma_rdata),
    .dma_ack     (dma_ack),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main memory: synchronous single-port RAM with registered read data.
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_data_in;
    if (mem_rd) mem_data_out <= ram[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One isolated access from an idle arbiter: request is seen at the next
  // edge, ISSUE follows one cycle later and ACK two cycles after that.
  task automatic applyStimulus(input int idx, input vec_t v);
    @(posedge clk); #1;
    if (v.port) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d_cpu_ack_c%0d", idx, c), 32'(cpu_ack), 32'(c == 3 && !v.port));
      checkOutput($sformatf("vec%0d_dma_ack_c%0d", idx, c), 32'(dma_ack), 32'(c == 3 && v.port));
      checkOutput($sformatf("vec%0d_mem_rd_c%0d", idx, c), 32'(mem_rd), 32'(c == 1 && !v.we));
      checkOutput($sformatf("vec%0d_mem_we_c%0d", idx, c), 32'(mem_we), 32'(c == 1 && v.we));
      if (c == 1) begin
        checkOutput($sformatf("vec%0d_mem_addr", idx), 32'(mem_addr), 32'(v.addr));
        if (v.we) checkOutput($sformatf("vec%0d_mem_data_in", idx), 32'(mem_data_in), 32'(v.wdata));
      end
      if (c == 3) begin
        checkOutput($sformatf("vec%0d_rdata", idx), 32'(v.port ? dma_rdata : cpu_rdata), 32'(v.exp_rdata));
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  // Reference model state for the randomized run.
  int            free_cyc, issue_cyc, ack_cyc, wait_model;
  bit            g_port, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, g_data, last_rd;
  bit            e_cpu_ack, e_dma_ack;
  int            n_acks, last_ack;

  function automatic logic [AW-1:0] randAddr();
    logic [AW-1:0] a;
    if ($urandom_range(0, 9) == 0) a = '1;
    else a = AW'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    vecs[0] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 8'h3C, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 13'h0000, 8'h11, 8'h3C};
    vecs[4] = '{1'b0, 1'b0, 13'h0000, 8'h00, 8'h11};
    vecs[5] = '{1'b1, 1'b0, 13'h0123, 8'h00, 8'hA5};
    vecs[6] = '{1'b0, 1'b1, 13'h1FFF, 8'hFF, 8'hA5};
    vecs[7] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hFF};

    preload(13'h0123, 8'hA5);
    preload(13'h0010, 8'h5A);
    @(posedge clk); #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("reset_strobes", 32'({mem_rd, mem_we, cpu_ack, dma_ack}), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_data_in", 32'(mem_data_in), 32'd0);
    checkOutput("reset_rdata", 32'(cpu_rdata), 32'd0);

    $display("[TB] single-access vector table");
    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    $display("[TB] reset during ISSUE of a CPU write");
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h77;
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_strobes", 32'({mem_rd, mem_we, cpu_ack, dma_ack}), 32'd0);
    checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("abort_mem_data_in", 32'(mem_data_in), 32'd0);
    checkOutput("abort_rdata", 32'(cpu_rdata), 32'd0);

    $display("[TB] idle for 20 cycles");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_c%0d", c), 32'({mem_rd, mem_we, cpu_ack, dma_ack}), 32'd0);
    end
    checkOutput("abort_ram_unchanged", 32'(ram[13'h0010]), 32'h5A);

    $display("[TB] simultaneous requests with empty wait count");
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("both_cpu_ack_c%0d", c), 32'(cpu_ack), 32'(c == 3));
      checkOutput($sformatf("both_dma_ack_c%0d", c), 32'(dma_ack), 32'(c == 7));
      if (c == 3) checkOutput("both_cpu_rdata", 32'(cpu_rdata), 32'hA5);
      if (c == 7) checkOutput("both_dma_rdata", 32'(dma_rdata), 32'h11);
      @(posedge clk); #1;
      if (c == 3) cpu_req = 1'b0;
      if (c == 7) dma_req = 1'b0;
    end

    $display("[TB] continuous contention grant order");
    applyReset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h0000;
    n_acks = 0; last_ack = 0;
    for (int c = 0; c < 60 && n_acks < 10; c++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        checkOutput($sformatf("seq%0d_grant", n_acks), 32'({dma_ack, cpu_ack}), (n_acks % 5 == 4) ? 32'd2 : 32'd1);
        if (n_acks > 0) checkOutput($sformatf("seq%0d_spacing", n_acks), 32'(c - last_ack), 32'd4);
        last_ack = c;
        n_acks++;
      end
    end
    checkOutput("seq_ack_count", 32'(n_acks), 32'd10);

    $display("[TB] randomized two-requester run");
    applyReset();
    for (int i = 0; i < (1 << AW); i++) shadow[i] = ram[i];
    free_cyc = 0; issue_cyc = -1; ack_cyc = -1; wait_model = 0;
    g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_data = '0; last_rd = '0;
    for (int cyc = 0; cyc < NRAND; cyc++) begin
      @(negedge clk);
      e_cpu_ack = (ack_cyc == cyc) && !g_port;
      e_dma_ack = (ack_cyc == cyc) && g_port;
      checkOutput("rnd_cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
      checkOutput("rnd_dma_ack", 32'(dma_ack), 32'(e_dma_ack));
      checkOutput("rnd_mem_rd", 32'(mem_rd), 32'(issue_cyc == cyc && !g_we));
      checkOutput("rnd_mem_we", 32'(mem_we), 32'(issue_cyc == cyc && g_we));
      if (issue_cyc == cyc) begin
        checkOutput("rnd_mem_addr", 32'(mem_addr), 32'(g_addr));
        if (g_we) checkOutput("rnd_mem_data_in", 32'(mem_data_in), 32'(g_wdata));
      end
      if (e_cpu_ack) checkOutput("rnd_cpu_rdata", 32'(cpu_rdata), 32'(g_data));
      if (e_dma_ack) checkOutput("rnd_dma_rdata", 32'(dma_rdata), 32'(g_data));

      if (cyc >= free_cyc && (cpu_req || dma_req)) begin
        if (cpu_req && dma_req) g_port = (wait_model >= MAXWAIT);
        else g_port = dma_req;
        if (g_port) wait_model = 0;
        else if (dma_req && wait_model < 15) wait_model++;
        g_we    = g_port ? dma_we    : cpu_we;
        g_addr  = g_port ? dma_addr  : cpu_addr;
        g_wdata = g_port ? dma_wdata : cpu_wdata;
        if (g_we) begin
          shadow[g_addr] = g_wdata;
          g_data = last_rd;
        end else begin
          g_data  = shadow[g_addr];
          last_rd = g_data;
        end
        issue_cyc = cyc + 1;
        ack_cyc   = cyc + 3;
        free_cyc  = cyc + 4;
      end

      @(posedge clk); #1;
      if (e_cpu_ack || !cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = randAddr(); cpu_wdata = DW'($urandom);
        end else begin
          cpu_req = 1'b0;
        end
      end
      if (e_dma_ack || !dma_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
          dma_addr = randAddr(); dma_wdata = DW'($urandom);
        end else begin
          dma_req = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
